// File: rtl/sram_data_arbiter.sv
// sram_data_arbiter
// Two-master round-robin arbiter in front of a single-port data SRAM.
// Master 0 is the core load/store unit, master 1 the debug/DMA loader.
// Grants are combinational (zero latency). Each grant produces exactly one
// registered response in the following cycle. Word addresses at or above
// DEPTH are blocked before they reach the array and answered with an error.

module sram_data_arbiter #(
  parameter int unsigned DEPTH     = 10,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,

  // master 0 (core load/store unit)
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  // master 1 (debug / DMA loader)
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  // SRAM port
  output logic        sram_req_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i
);

  // Array size widened once so the range check is a full 32-bit compare.
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Arbitration state: master that wins the next tie.
  logic        prio_q;

  // Response pipeline stage (one entry: no backpressure on responses).
  logic        rsp_valid_q;
  logic        rsp_owner_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Combinational arbitration and access decode.
  logic        grant;
  logic        winner;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;
  logic [31:0] rsp_rdata_d;

  // Pick this cycle's winner; reset suppresses every grant.
  // NOTE: every signal written in an always_comb gets a default on entry,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (!rst_i && (m0_req_i || m1_req_i)) begin
      grant = 1'b1;
      if (m0_req_i && m1_req_i) begin
        winner = prio_q;
      end else begin
        winner = m1_req_i;
      end
    end
  end

  // Route the winning master's access fields; zero when nobody is granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    if (grant) begin
      if (winner) begin
        sel_we    = m1_we_i;
        sel_addr  = m1_addr_i;
        sel_wdata = m1_wdata_i;
      end else begin
        sel_we    = m0_we_i;
        sel_addr  = m0_addr_i;
        sel_wdata = m0_wdata_i;
      end
    end
  end

  // Out-of-range words never strobe the array, so such writes are dropped.
  assign in_range = (sel_addr < DEPTH_W);

  // Drive the SRAM port from the selected access.
  always_comb begin
    sram_req_o   = grant & in_range;
    sram_we_o    = grant & in_range & sel_we;
    sram_addr_o  = sel_addr;
    sram_wdata_o = sel_wdata;
  end

  // Per-master grant strobes.
  always_comb begin
    m0_gnt_o = grant & ~winner;
    m1_gnt_o = grant &  winner;
  end

  // Data to capture for the response: error word, zero for a write ack,
  // or the array's combinational read data.
  always_comb begin
    rsp_rdata_d = 32'h0;
    if (!in_range) begin
      rsp_rdata_d = ERR_RDATA;
    end else if (!sel_we) begin
      rsp_rdata_d = sram_rdata_i;
    end
  end

  // Advance the tie-break and capture the response at the grant edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      if (grant) begin
        prio_q      <= ~winner;
        rsp_owner_q <= winner;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= ~in_range;
      end
    end
  end

  // Steer the registered response to its owner. A response that was still
  // pending when reset rose is hidden immediately rather than leaking out
  // during the reset cycle.
  always_comb begin
    m0_rvalid_o = rsp_valid_q & ~rst_i & ~rsp_owner_q;
    m1_rvalid_o = rsp_valid_q & ~rst_i &  rsp_owner_q;
    m0_rdata_o  = m0_rvalid_o ? rsp_rdata_q : 32'h0;
    m1_rdata_o  = m1_rvalid_o ? rsp_rdata_q : 32'h0;
    m0_err_o    = m0_rvalid_o & rsp_err_q;
    m1_err_o    = m1_rvalid_o & rsp_err_q;
  end

endmodule

// File: tb/tb_sram_data_arbiter.sv
// tb_sram_data_arbiter
// Directed scenarios followed by randomized traffic. The reference model
// tracks the tie-break owner, an expected copy of memory and the response
// expected next cycle; a separate behavioural SRAM serves the DUT.

module tb_sram_data_arbiter;

  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_req, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_data_arbiter #(.DEPTH(DEPTH), .ERR_RDATA(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_000f;
      3:       return 32'h0000_0010;
      9:       return 32'h5050_5050;
      default: return 32'h1111_0000 | 32'(i);
    endcase
  endfunction

  // Behavioural SRAM seen by the DUT: combinational read, write on the edge.
  logic [31:0] sram_mem [DEPTH];
  logic        load_mem = 1'b1;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
    end else if (sram_req && sram_we && sram_addr < DEPTH) begin
      sram_mem[sram_addr[3:0]] <= sram_wdata;
    end
  end

  always_comb begin
    sram_rdata = 32'hDEAD_BEEF;
    if (sram_addr < DEPTH) sram_rdata = sram_mem[sram_addr[3:0]];
  end

  // Shadow stimulus, applied to the DUT on the falling edge.
  bit          s_rst;
  bit          s_req [2];
  bit          s_we  [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];

  // Reference model state.
  int          prio_m;
  logic [31:0] ref_mem [DEPTH];
  bit          exp_v;
  int          exp_o;
  logic [31:0] exp_rd;
  bit          exp_err;
  int          last_w = -1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r < 12) return 32'($urandom_range(0, DEPTH - 1));
    case (r)
      12:      return 32'd10;
      13:      return 32'd11;
      14:      return 32'hFFFF_FFFF;
      default: return 32'($urandom) | 32'h0000_0100;
    endcase
  endfunction

  // Masters hold a request until granted, then may issue a new one at once.
  task automatic gen_stim();
    for (int n = 0; n < 2; n++) begin
      if (last_w == n || !s_req[n]) begin
        if ($urandom_range(0, 9) < 7) begin
          s_req[n]   = 1'b1;
          s_we[n]    = 1'($urandom_range(0, 1));
          s_addr[n]  = pick_addr();
          s_wdata[n] = 32'($urandom);
        end else begin
          s_req[n] = 1'b0;
        end
      end
    end
    s_rst = ($urandom_range(0, 99) == 0);
  endtask

  // One clock cycle: apply stimulus, check the response launched by the
  // previous edge, check this cycle's grant, then advance the model.
  task automatic step(input bit auto_stim);
    int   w;
    bit   inr;
    bit   rv_e [2];
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    if (auto_stim) gen_stim();
    rst      = s_rst;
    m0_req   = s_req[0];   m1_req   = s_req[1];
    m0_we    = s_we[0];    m1_we    = s_we[1];
    m0_addr  = s_addr[0];  m1_addr  = s_addr[1];
    m0_wdata = s_wdata[0]; m1_wdata = s_wdata[1];
    #1;
    for (int n = 0; n < 2; n++) rv_e[n] = !s_rst && exp_v && (exp_o == n);
    check("m0_rvalid", 32'(m0_rvalid), 32'(rv_e[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rv_e[1]));
    check("m0_rdata",  m0_rdata, rv_e[0] ? exp_rd : 32'h0);
    check("m1_rdata",  m1_rdata, rv_e[1] ? exp_rd : 32'h0);
    check("m0_err",    32'(m0_err), 32'(rv_e[0] && exp_err));
    check("m1_err",    32'(m1_err), 32'(rv_e[1] && exp_err));

    if (s_rst)                     w = -1;
    else if (s_req[0] && s_req[1]) w = prio_m;
    else if (s_req[0])             w = 0;
    else if (s_req[1])             w = 1;
    else                           w = -1;
    inr     = (w >= 0) && (s_addr[w] < DEPTH);
    e_addr  = (w >= 0) ? s_addr[w]  : 32'h0;
    e_wdata = (w >= 0) ? s_wdata[w] : 32'h0;
    check("m0_gnt",     32'(m0_gnt),   32'(w == 0));
    check("m1_gnt",     32'(m1_gnt),   32'(w == 1));
    check("sram_req",   32'(sram_req), 32'(inr));
    check("sram_we",    32'(sram_we),  32'(inr && s_we[w]));
    check("sram_addr",  sram_addr,  e_addr);
    check("sram_wdata", sram_wdata, e_wdata);

    if (s_rst) begin
      exp_v  = 1'b0;
      prio_m = 0;
    end else begin
      exp_v = (w >= 0);
      if (w >= 0) begin
        exp_o   = w;
        exp_err = !inr;
        if (!inr)          exp_rd = 32'h0;
        else if (s_we[w])  exp_rd = 32'h0;
        else               exp_rd = ref_mem[s_addr[w]];
        if (inr && s_we[w]) ref_mem[s_addr[w]] = s_wdata[w];
        prio_m = 1 - w;
      end
    end
    last_w = w;
  endtask

  task automatic idle_masters();
    s_req[0] = 1'b0;
    s_req[1] = 1'b0;
  endtask

  task automatic set_req(input int n, input bit we, input logic [31:0] a, input logic [31:0] d);
    s_req[n]   = 1'b1;
    s_we[n]    = we;
    s_addr[n]  = a;
    s_wdata[n] = d;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    for (int n = 0; n < 2; n++) begin
      s_req[n] = 1'b0; s_we[n] = 1'b0; s_addr[n] = 32'h0; s_wdata[n] = 32'h0;
    end
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    prio_m = 0; exp_v = 1'b0; exp_o = 0; exp_rd = 32'h0; exp_err = 1'b0;

    // Reset for two cycles, then idle.
    s_rst = 1'b1;
    step(1'b0);
    load_mem = 1'b0;
    step(1'b0);
    s_rst = 1'b0;
    step(1'b0);
    step(1'b0);

    // Single master read of word 3.
    set_req(0, 1'b0, 32'd3, 32'h0);
    step(1'b0);
    check("single_gnt", 32'(m0_gnt), 32'd1);
    idle_masters();
    step(1'b0);
    check("single_rdata", m0_rdata, 32'h0000_0010);

    // Contention alternation starting from a fresh reset.
    s_rst = 1'b1;
    step(1'b0);
    s_rst = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'h0);
    set_req(1, 1'b0, 32'd9, 32'h0);
    step(1'b0);
    check("cont_first_m0", 32'(m0_gnt), 32'd1);
    step(1'b0);
    check("cont_second_m1", 32'(m1_gnt), 32'd1);
    check("cont_rd_m0", m0_rdata, 32'h0000_000f);
    step(1'b0);
    check("cont_rd_m1", m1_rdata, 32'h5050_5050);
    step(1'b0);
    idle_masters();
    step(1'b0);

    // Cross-master read-after-write on word 5.
    set_req(1, 1'b1, 32'd5, 32'hCAFE_F00D);
    step(1'b0);
    s_req[1] = 1'b0;
    set_req(0, 1'b0, 32'd5, 32'h0);
    step(1'b0);
    check("raw_wack", m1_rdata, 32'h0);
    idle_masters();
    step(1'b0);
    check("raw_rdata", m0_rdata, 32'hCAFE_F00D);

    // Out-of-range write then read.
    set_req(0, 1'b1, 32'd10, 32'h1234_5678);
    step(1'b0);
    check("oor_wr_blocked", 32'(sram_req), 32'd0);
    set_req(0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    step(1'b0);
    check("oor_rd_blocked", 32'(sram_req), 32'd0);
    check("oor_wr_err", 32'(m0_err), 32'd1);
    idle_masters();
    step(1'b0);
    check("oor_rd_err", 32'(m0_err), 32'd1);
    check("oor_rd_data", m0_rdata, 32'h0);
    for (int i = 0; i < DEPTH; i++) check("oor_mem", sram_mem[i], ref_mem[i]);

    // Reset mid-operation with requests held through reset.
    set_req(1, 1'b0, 32'd2, 32'h0);
    step(1'b0);
    s_rst = 1'b1;
    set_req(0, 1'b0, 32'd1, 32'h0);
    step(1'b0);
    check("rst_mid_no_rv", 32'(m1_rvalid), 32'd0);
    s_rst = 1'b0;
    step(1'b0);
    check("rst_after_no_rv", 32'(m1_rvalid), 32'd0);
    check("rst_after_tie_m0", 32'(m0_gnt), 32'd1);
    idle_masters();
    step(1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) step(1'b1);
    s_rst = 1'b0;
    idle_masters();
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < DEPTH; i++) check("final_mem", sram_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
